updown_count_ctrl: RTL and testbench

Command-driven sequencer for an N-bit up/down counter datapath. It accepts one command at a time over a valid/ready handshake: load, clear, count up N steps, or count down N steps. It then steps the counter one count per clock, reports completion and wrap-around, and returns to idle. It sits between a host/test controller and the counter core, replacing free-running counting with scheduled, bounded runs.

---
 rtl/updown_ctrl_pkg.sv | 15 +
 rtl/updown_counter_core.sv | 22 ++
 rtl/updown_count_ctrl.sv | 80 ++++++++
 tb/tb_updown_count_ctrl.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/updown_ctrl_pkg.sv
// updown_ctrl_pkg: command opcodes and controller state encodings for updown_count_ctrl
package updown_ctrl_pkg;
  typedef enum logic [1:0] {
    OP_LOAD  = 2'b00,
    OP_UP    = 2'b01,
    OP_DOWN  = 2'b10,
    OP_CLEAR = 2'b11
  } cmd_op_e;
  typedef enum logic [1:0] {
    IDLE     = 2'b00,
    RUN_UP   = 2'b01,
    RUN_DOWN = 2'b10,
    DONE     = 2'b11
  } ctrl_state_e;
endpackage

// File: rtl/updown_counter_core.sv
// updown_counter_core: WIDTH-bit modulo up/down counter with sync load (clk, reset, en, up, load, load_val -> count, wrap_next)
module updown_counter_core #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             en,
  input  logic             up,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             wrap_next
);
  logic [WIDTH-1:0] count_q;
  always_ff @(posedge clk) begin
    if (reset) count_q <= '0;
    else if (load) count_q <= load_val;
    else if (en) count_q <= up ? count_q + 1'b1 : count_q - 1'b1;
  end
  assign count     = count_q;
  assign wrap_next = en && !load && (up ? &count_q : ~|count_q);
endmodule

// File: rtl/updown_count_ctrl.sv
// updown_count_ctrl: valid/ready command sequencer for up/down counter (LOAD/UP/DOWN/CLEAR -> count, busy, done, wrap); `define PAUSE_EN adds pause input
module updown_count_ctrl
  import updown_ctrl_pkg::*;
#(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [1:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_arg,
  output logic [WIDTH-1:0] count,
  output logic             busy,
  output logic             done,
  output logic             wrap
`ifdef PAUSE_EN
  ,
  input  logic             pause
`endif
);
  ctrl_state_e      state_q, state_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic             wrap_q, wrap_next, accept, hold, running, step, is_set;
  cmd_op_e          op;
`ifdef PAUSE_EN
  assign hold = pause;
`else
  assign hold = 1'b0;
`endif
  assign op        = cmd_op_e'(cmd_op);
  assign cmd_ready = (state_q == IDLE) && !reset;
  assign accept    = cmd_valid && cmd_ready;
  assign running   = (state_q == RUN_UP) || (state_q == RUN_DOWN);
  assign step      = running && !hold;
  assign is_set    = (op == OP_LOAD) || (op == OP_CLEAR);
  updown_counter_core #(.WIDTH(WIDTH)) u_core (
    .clk       (clk),
    .reset     (reset),
    .en        (step),
    .up        (state_q == RUN_UP),
    .load      (accept && is_set),
    .load_val  ((op == OP_CLEAR) ? '0 : cmd_arg),
    .count     (count),
    .wrap_next (wrap_next)
  );
  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    unique case (state_q)
      IDLE: if (accept) begin
        if (is_set || cmd_arg == '0) state_d = DONE;
        else begin
          rem_d   = cmd_arg;
          state_d = (op == OP_UP) ? RUN_UP : RUN_DOWN;
        end
      end
      RUN_UP, RUN_DOWN: if (step) begin
        rem_d   = rem_q - 1'b1;
        state_d = (rem_q == 1) ? DONE : state_q;
      end
      DONE: state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      rem_q   <= '0;
      wrap_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      wrap_q  <= wrap_next;
    end
  end
  assign busy = state_q != IDLE;
  assign done = state_q == DONE;
  assign wrap = wrap_q;
endmodule

// File: tb/tb_updown_count_ctrl.sv
// tb_updown_count_ctrl: directed self-checking bench for updown_count_ctrl
module tb_updown_count_ctrl;
  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       cmd_valid = 1'b0;
  logic       cmd_ready;
  logic [1:0] cmd_op = 2'b00;
  logic [3:0] cmd_arg = 4'd0;
  logic [3:0] count;
  logic       busy, done, wrap;
  logic       pause = 1'b0;
  int         nvec = 0;
  int         nerr = 0;
  always #5 clk = ~clk;
  updown_count_ctrl #(.WIDTH(4)) dut (
    .clk       (clk),
    .reset     (reset),
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_op    (cmd_op),
    .cmd_arg   (cmd_arg),
    .count     (count),
    .busy      (busy),
    .done      (done),
    .wrap      (wrap)
`ifdef PAUSE_EN
    ,
    .pause     (pause)
`endif
  );
  task automatic cyc();
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask
  task automatic chk_st(input string tag, input logic [3:0] c, input logic rdy, input logic b,
                        input logic d, input logic w);
    chk({tag, ".count"}, 32'(count), 32'(c));
    chk({tag, ".ready"}, 32'(cmd_ready), 32'(rdy));
    chk({tag, ".busy"}, 32'(busy), 32'(b));
    chk({tag, ".done"}, 32'(done), 32'(d));
    chk({tag, ".wrap"}, 32'(wrap), 32'(w));
  endtask
  task automatic issue(input logic [1:0] op, input logic [3:0] arg);
    cmd_valid = 1'b1;
    cmd_op    = op;
    cmd_arg   = arg;
    cyc();
    cmd_valid = 1'b0;
  endtask
  initial begin
    cyc();
    chk_st("rst_hold", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc();
    reset = 1'b0;
    #1;
    chk_st("rst_rel", 4'd0, 1'b1, 1'b0, 1'b0, 1'b0);
    issue(2'b00, 4'd9);
    chk_st("load9_acc", 4'd9, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc();
    chk_st("load9_idle", 4'd9, 1'b1, 1'b0, 1'b0, 1'b0);
    issue(2'b00, 4'd14);
    cyc();
    issue(2'b01, 4'd3);
    chk_st("up3_acc", 4'd14, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc();
    chk_st("up3_s1", 4'd15, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc();
    chk_st("up3_s2", 4'd0, 1'b0, 1'b1, 1'b0, 1'b1);
    cyc();
    chk_st("up3_s3", 4'd1, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc();
    chk_st("up3_idle", 4'd1, 1'b1, 1'b0, 1'b0, 1'b0);
    issue(2'b00, 4'd2);
    cyc();
    issue(2'b10, 4'd4);
    chk_st("dn4_acc", 4'd2, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc();
    chk_st("dn4_s1", 4'd1, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc();
    chk_st("dn4_s2", 4'd0, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc();
    chk_st("dn4_s3", 4'd15, 1'b0, 1'b1, 1'b0, 1'b1);
    cyc();
    chk_st("dn4_s4", 4'd14, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc();
    chk_st("dn4_idle", 4'd14, 1'b1, 1'b0, 1'b0, 1'b0);
    issue(2'b01, 4'd0);
    chk_st("up0_acc", 4'd14, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc();
    chk_st("up0_idle", 4'd14, 1'b1, 1'b0, 1'b0, 1'b0);
    issue(2'b11, 4'd7);
    chk_st("clr_acc", 4'd0, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc();
    issue(2'b01, 4'd10);
    repeat (5) cyc();
    chk_st("up10_s5", 4'd5, 1'b0, 1'b1, 1'b0, 1'b0);
    reset     = 1'b1;
    cmd_valid = 1'b1;
    cmd_op    = 2'b00;
    cmd_arg   = 4'd3;
    #1;
    chk("rst_mid.ready", 32'(cmd_ready), 32'd0);
    cyc();
    chk_st("rst_mid_e1", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    cyc();
    chk_st("rst_mid_e2", 4'd0, 1'b0, 1'b0, 1'b0, 1'b0);
    reset = 1'b0;
    #1;
    chk("rst_drop.ready", 32'(cmd_ready), 32'd1);
    cyc();
    cmd_valid = 1'b0;
    chk_st("held_load3", 4'd3, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc();
`ifdef PAUSE_EN
    issue(2'b11, 4'd0);
    cyc();
    issue(2'b01, 4'd5);
    cyc();
    cyc();
    chk_st("p_s2", 4'd2, 1'b0, 1'b1, 1'b0, 1'b0);
    pause = 1'b1;
    for (int i = 0; i < 3; i++) begin
      cyc();
      chk_st("p_hold", 4'd2, 1'b0, 1'b1, 1'b0, 1'b0);
    end
    pause = 1'b0;
    cyc();
    chk_st("p_s3", 4'd3, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc();
    chk_st("p_s4", 4'd4, 1'b0, 1'b1, 1'b0, 1'b0);
    cyc();
    chk_st("p_s5", 4'd5, 1'b0, 1'b1, 1'b1, 1'b0);
    cyc();
    chk_st("p_idle", 4'd5, 1'b1, 1'b0, 1'b0, 1'b0);
`endif
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
